// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: accepts one cache miss, issues a block read and streams the 16 returned
// beats to the cache write port. Optional macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN enables critical-word-first ordering.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH  = 24,
    parameter int OFFSET_BITS = 6,
    parameter int WORD_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rdata_valid,
    input  logic [31:0]           mem_rdata,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [31:0]           fill_data,
    output logic                  fill_done,
    output logic                  busy,
    output logic [31:0]           miss_count,
    output logic                  protocol_err
);

    localparam int IDX_W = OFFSET_BITS - WORD_BITS;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    localparam logic [ADDR_WIDTH-1:0] REQ_MASK = {ADDR_WIDTH{1'b1}} << WORD_BITS;
`else
    localparam logic [ADDR_WIDTH-1:0] REQ_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
`endif

    typedef enum logic [1:0] {IDLE, REQ, BEATS, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] first_idx;
    logic [31:0]      miss_cnt;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign first_idx = miss_addr[OFFSET_BITS-1:WORD_BITS];
`else
    assign first_idx = '0;
`endif

    // The block is complete once the wrapping word index comes back round to where it started.
    assign next_idx = beat_idx + IDX_ONE;

    assign miss_ready    = (state == IDLE);
    assign busy          = (state != IDLE);
    assign mem_req_valid = (state == REQ);
    assign fill_done     = (state == DONE);
    assign miss_count    = miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat_idx     <= '0;
            start_idx    <= '0;
            mem_req_addr <= '0;
            fill_valid   <= 1'b0;
            fill_addr    <= '0;
            fill_data    <= '0;
            miss_cnt     <= '0;
            protocol_err <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            // Beats outside a block transfer are dropped but remembered.
            if (mem_rdata_valid && (state != BEATS))
                protocol_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        mem_req_addr <= miss_addr & REQ_MASK;
                        start_idx    <= first_idx;
                        beat_idx     <= first_idx;
                        if (miss_cnt != '1)
                            miss_cnt <= miss_cnt + 32'd1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready)
                        state <= BEATS;
                end
                BEATS: begin
                    if (mem_rdata_valid) begin
                        fill_valid <= 1'b1;
                        fill_addr  <= {mem_req_addr[ADDR_WIDTH-1:OFFSET_BITS], beat_idx,
                                       {WORD_BITS{1'b0}}};
                        fill_data  <= mem_rdata;
                        beat_idx   <= next_idx;
                        if (next_idx == start_idx)
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: table of miss scenarios plus hand-written reset,
// protocol-error and saturation sequences; fills are checked against a scoreboard queue.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic        miss_ready;
    logic [23:0] miss_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [23:0] mem_req_addr;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        fill_valid;
    logic [23:0] fill_addr;
    logic [31:0] fill_data;
    logic        fill_done;
    logic        busy;
    logic [31:0] miss_count;
    logic        protocol_err;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .miss_valid      (miss_valid),
        .miss_ready      (miss_ready),
        .miss_addr       (miss_addr),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .fill_valid      (fill_valid),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .fill_done       (fill_done),
        .busy            (busy),
        .miss_count      (miss_count),
        .protocol_err    (protocol_err)
    );

    typedef struct {
        logic [23:0] a;
        logic [31:0] d;
    } fill_t;

    typedef struct {
        logic [23:0] addr;
        int          req_delay;
        int          max_gap;
        logic [31:0] dbase;
        logic [23:0] exp_req;
        bit          hold_next;
    } vec_t;

    fill_t       sb[$];
    fill_t       mon_e;
    vec_t        tbl[4];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fills_seen = 0;
    int          cyc = 0;
    logic [31:0] exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_fill_addr(input logic [23:0] a, input int i);
        logic [3:0] s;
        logic [3:0] idx;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        s = a[5:2];
`else
        s = 4'd0;
`endif
        idx = s + 4'(i);
        return {a[23:6], idx, 2'b00};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: every fill must match the oldest expected beat.
    initial forever begin
        @(negedge clk);
        if (fill_valid === 1'b1) begin
            fills_seen++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_fill: got addr 0x%0h data 0x%0h, expected no fill",
                         fill_addr, fill_data);
            end else begin
                mon_e = sb.pop_front();
                check("fill_addr", 32'(fill_addr), 32'(mon_e.a));
                check("fill_data", fill_data, mon_e.d);
            end
        end
    end

    task automatic drive_beat(input logic [23:0] addr, input int i, input logic [31:0] dbase);
        fill_t e;
        mem_rdata_valid = 1'b1;
        mem_rdata       = dbase + 32'(i);
        e.a = exp_fill_addr(addr, i);
        e.d = dbase + 32'(i);
        sb.push_back(e);
        @(negedge clk);
        mem_rdata_valid = 1'b0;
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic run_refill(input vec_t v, input logic [23:0] next_addr);
        int t_acc;
        int f0;
        int gap;
        f0 = fills_seen;
        miss_valid = 1'b1;
        miss_addr  = v.addr;
        check("miss_ready_idle", 32'(miss_ready), 32'd1);
        @(negedge clk);
        t_acc   = cyc;
        exp_cnt = (exp_cnt == 32'hFFFF_FFFF) ? exp_cnt : exp_cnt + 32'd1;
        if (v.hold_next) miss_addr = next_addr;
        else miss_valid = 1'b0;
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", 32'(mem_req_addr), 32'(v.exp_req));
        check("miss_ready_req", 32'(miss_ready), 32'd0);
        check("busy_req", 32'(busy), 32'd1);
        mem_req_ready = 1'b0;
        for (int d = 0; d < v.req_delay; d++) begin
            @(negedge clk);
            check("req_valid_held", 32'(mem_req_valid), 32'd1);
            check("req_addr_held", 32'(mem_req_addr), 32'(v.exp_req));
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("req_dropped", 32'(mem_req_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            gap = (v.max_gap > 0) ? int'($urandom_range(v.max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            drive_beat(v.addr, i, v.dbase);
        end
        check("fill_done_pulse", 32'(fill_done), 32'd1);
        check("fill_with_done", 32'(fill_valid), 32'd1);
        check("miss_count", miss_count, exp_cnt);
        // Acceptance edge T to fill_done cycle T+18 spans 17 clock edges.
        if (v.req_delay == 0 && v.max_gap == 0)
            check("latency_edges", 32'(cyc - t_acc), 32'd17);
        @(negedge clk);
        check("fill_done_once", 32'(fill_done), 32'd0);
        check("miss_ready_after", 32'(miss_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("fill_count", 32'(fills_seen - f0), 32'd16);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        miss_valid      = 1'b0;
        miss_addr       = '0;
        mem_req_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        tbl[0] = '{24'h1234B7, 0, 0, 32'hA0,  24'h1234B4, 1'b0};
        tbl[1] = '{24'h000074, 0, 0, 32'h100, 24'h000074, 1'b0};
        tbl[2] = '{24'h00ABFC, 5, 3, 32'h200, 24'h00ABFC, 1'b1};
        tbl[3] = '{24'hFFFFC8, 1, 0, 32'h300, 24'hFFFFC8, 1'b0};
`else
        tbl[0] = '{24'h1234B7, 0, 0, 32'hA0,  24'h123480, 1'b0};
        tbl[1] = '{24'h000074, 0, 0, 32'h100, 24'h000040, 1'b0};
        tbl[2] = '{24'h00ABFC, 5, 3, 32'h200, 24'h00ABC0, 1'b1};
        tbl[3] = '{24'hFFFFC8, 1, 0, 32'h300, 24'hFFFFC0, 1'b0};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_miss_ready", 32'(miss_ready), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_req_addr", 32'(mem_req_addr), 32'd0);
        check("rst_fill_valid", 32'(fill_valid), 32'd0);
        check("rst_fill_addr", 32'(fill_addr), 32'd0);
        check("rst_fill_data", fill_data, 32'd0);
        check("rst_fill_done", 32'(fill_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        check("rst_protocol_err", 32'(protocol_err), 32'd0);

        // Stray beat while idle: dropped and flagged.
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        check("stray_no_fill", 32'(fill_valid), 32'd0);
        check("stray_err", 32'(protocol_err), 32'd1);
        @(negedge clk);
        check("stray_err_held", 32'(protocol_err), 32'd1);

        for (int i = 0; i < 4; i++)
            run_refill(tbl[i], (i < 3) ? tbl[i+1].addr : 24'h0);
        check("err_sticky", 32'(protocol_err), 32'd1);

        // Reset after the seventh beat abandons the refill.
        miss_valid = 1'b1;
        miss_addr  = 24'h000A5C;
        @(negedge clk);
        miss_valid    = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) drive_beat(24'h000A5C, i, 32'h700);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_idle", 32'(miss_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fill_valid", 32'(fill_valid), 32'd0);
        check("mid_rst_count", miss_count, 32'd0);
        check("mid_rst_err", 32'(protocol_err), 32'd0);
        check("mid_rst_sb", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_done", 32'(fill_done), 32'd0);
            @(negedge clk);
        end
        exp_cnt = 32'd0;
        run_refill(tbl[0], 24'h0);
        check("err_clear_after", 32'(protocol_err), 32'd0);

        // Saturation of the miss counter.
        force dut.miss_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.miss_cnt;
        check("sat_preload", miss_count, 32'hFFFF_FFFE);
        exp_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) run_refill(tbl[0], 24'h0);
        check("sat_final", miss_count, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-refill controller sitting directly downstream of the set-associative instruction cache. It accepts one miss at a time (24-bit byte address) over a valid/ready handshake and issues a block read to the backing memory. It collects the 16 returned 32-bit beats and streams them to the cache data/tag write port, then pulses completion. It also keeps a saturating miss counter and a sticky protocol-error flag for the hit/miss bench.

## Interface
Parameters:
- ADDR_WIDTH, 24, byte-address width of a miss
- OFFSET_BITS, 6, log2 of block size (64 B blocks)
- WORD_BITS, 2, log2 of beat size in bytes (32-bit beats); beats per block = 2^(OFFSET_BITS-WORD_BITS) = 16

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  cache presents a miss
- miss_ready  out  1  controller can accept a miss
- miss_addr  in  ADDR_WIDTH  missing byte address
- mem_req_valid  out  1  block read request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  request address
- mem_rdata_valid  in  1  one beat of read data present
- mem_rdata  in  32  beat data
- fill_valid  out  1  one word to write into the cache
- fill_addr  out  ADDR_WIDTH  byte address of the word being filled
- fill_data  out  32  word data
- fill_done  out  1  one-cycle pulse: block complete, cache may set valid and reset LRU
- busy  out  1  high whenever state != IDLE (fetch stall)
- miss_count  out  32  accepted misses, saturating
- protocol_err  out  1  sticky: beat received when none expected

## Operation
- FSM states: IDLE, REQ, BEATS, DONE.
- IDLE: miss_ready=1. On miss_valid&&miss_ready, capture miss_addr, clear beat counter, go to REQ, and increment miss_count, holding at 0xFFFFFFFF.
- REQ: mem_req_valid=1 and mem_req_addr stable until mem_req_ready is sampled high, then go to BEATS. miss_ready=0.
- BEATS: each cycle with mem_rdata_valid, register one fill word and increment the 4-bit beat counter. When the 16th beat is accepted, go to DONE. Gaps between beats are allowed and have no timeout.
- DONE: fill_done=1 for exactly one cycle, then IDLE.
- fill_addr = {block address, word index, 2'b00}. The word index computation is set by the configuration below; it wraps modulo 16.
- mem_rdata_valid in IDLE, REQ or DONE is dropped (no fill is produced) and sets protocol_err. Only rst clears protocol_err.
- A miss presented while busy is not accepted; miss_valid must hold with miss_addr stable until accepted.
- Reset values: state IDLE, miss_ready 1 (from the first cycle after reset), mem_req_valid 0, mem_req_addr 0, fill_valid 0, fill_addr 0, fill_data 0, fill_done 0, busy 0, miss_count 0, protocol_err 0.
- rst mid-refill: abandon the transfer immediately. No fill_done, and the beat counter is cleared. miss_count and protocol_err are reset.

## Timing
- Miss accepted at edge T: mem_req_valid high during cycle T+1.
- If mem_req_ready is sampled high at edge T+1: BEATS during T+2.
- Beat sampled at edge k: fill_valid/fill_addr/fill_data high during cycle k+1 (1-cycle latency, registered).
- Last beat sampled at edge k: state DONE during k+1, so fill_done and the final fill_valid occur in the same cycle.
- IDLE, with miss_ready=1, during k+2.
- Best case miss-accept to fill_done: 18 cycles, with back-to-back beats from T+2.
- A new miss may be accepted at the first edge of the IDLE cycle; there is no dead cycle beyond DONE.

## Configuration
- CACHE_REFILL_CRITICAL_WORD_FIRST_EN defined:
  - mem_req_addr = miss_addr with bits [WORD_BITS-1:0] cleared.
  - The beat counter starts at the missing word's index, and beats are tagged with wrapping word index (e.g. 13,14,15,0,…,12).
  - The first fill_valid carries the requested word.
- Not defined:
  - mem_req_addr = miss_addr with bits [OFFSET_BITS-1:0] cleared.
  - Word index runs 0..15 in order, regardless of offset.

## Test plan
- Reset then idle: rst high 2 cycles -> all outputs at reset values, miss_ready=1. mem_rdata_valid pulse in IDLE -> no fill_valid, protocol_err=1 until next rst.
- Single miss, macro off: miss_addr=0x12_34B7, mem_req_ready=1, 16 back-to-back beats 0xA0..0xAF -> mem_req_addr=0x12_3480; fills 0x12_3480..0x12_34BC carrying 0xA0..0xAF; fill_done in the same cycle as the last fill, 18 cycles after acceptance; miss_count=1.
- Critical word first, macro on: miss_addr=0x00_0074 (word 13) -> mem_req_addr=0x00_0074; fill word indices 13,14,15,0..12; first fill_addr=0x00_0074; wrap 15->0 gives fill_addr 0x00_0040.
- Backpressure and gaps: mem_req_ready low for 5 cycles, then beats with a random 0–3 idle-cycle gap -> mem_req_valid/addr stable throughout REQ; exactly 16 fills; one fill_done; miss_valid held during busy is not accepted until IDLE.
- Reset mid-refill: rst asserted after beat 7 -> next cycle state IDLE, no fill_done, miss_count=0. A subsequent miss completes normally with 16 fills.
- Saturation: force miss_count to 0xFFFF_FFFE, complete 3 misses -> miss_count reads 0xFFFF_FFFF.
